// File: rtl/wfi_sleep_ctrl_pkg.sv
// Shared types for the WFI sleep controller: FSM state encoding and wake-cause codes.
package wfi_sleep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_IRQ   = 2'b01,
        CAUSE_TIMER = 2'b10,
        CAUSE_ABORT = 2'b11
    } cause_e;

endpackage

// File: rtl/wfi_sleep_ctrl_if.sv
// Core-side sleep handshake and LED pad bus of the sleep controller.
// The master modport is the core/SoC side; the slave modport is the controller.
interface wfi_sleep_ctrl_if #(
    parameter int TIMER_W = 24
);
    logic               wfi_req;
    logic               bus_idle;
    logic               irq_pending;
    logic [TIMER_W-1:0] wake_ticks;
    logic               led_we;
    logic [7:0]         led_wdata;
    logic [7:0]         led_bus;
    logic               wfi;
    logic               cpu_stall;
    logic               wfi_done;
    logic [1:0]         wake_cause;

    modport master (
        output wfi_req, bus_idle, irq_pending, wake_ticks, led_we, led_wdata,
        input  led_bus, wfi, cpu_stall, wfi_done, wake_cause
    );

    modport slave (
        input  wfi_req, bus_idle, irq_pending, wake_ticks, led_we, led_wdata,
        output led_bus, wfi, cpu_stall, wfi_done, wake_cause
    );

endinterface

// File: rtl/wfi_sleep_ctrl_wake_timer.sv
// Loadable wake-timer down-counter; a count of 0 is parked and never expires.
module wfi_wake_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    // Expiry is flagged while the count sits at 1, so sleep lasts exactly the loaded tick count.
    assign expire_o = en_i && (count_q == TIMER_W'(1));

endmodule

// File: rtl/wfi_sleep_ctrl.sv
// WFI sleep sequencer (drain, sleep, settle) plus the LED pad register held stable during sleep.
// Optional wake timer is built only when WFI_WAKE_TIMER_EN is defined.
module wfi_sleep_ctrl
    import wfi_sleep_ctrl_pkg::*;
#(
    parameter int         TIMER_W       = 24,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] LED_RESET     = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    wfi_sleep_ctrl_if.slave bus
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q;
    logic                wfi_q;
    logic                stall_q;
    logic                done_q;
    cause_e              cause_q;
    cause_e              pend_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [7:0]          led_q;
    logic                timer_load;
    logic                timer_en;
    logic                timer_expire;

    assign timer_load = (state_q == ST_DRAIN) && !bus.irq_pending && bus.bus_idle;
    assign timer_en   = (state_q == ST_SLEEP);

`ifdef WFI_WAKE_TIMER_EN
    wfi_wake_timer #(
        .TIMER_W (TIMER_W)
    ) u_wake_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (bus.wake_ticks),
        .en_i       (timer_en),
        .expire_o   (timer_expire)
    );
`else
    logic unused_timer;
    assign unused_timer = ^{bus.wake_ticks, timer_load, timer_en};
    assign timer_expire = 1'b0;
`endif

    // The wake cause is latched on leaving SLEEP but only published with the wfi_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            wfi_q    <= 1'b0;
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
            pend_q   <= CAUSE_NONE;
            settle_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (bus.wfi_req) begin
                        state_q <= ST_DRAIN;
                        stall_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.irq_pending) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                        done_q  <= 1'b1;
                        cause_q <= CAUSE_ABORT;
                    end else if (bus.bus_idle) begin
                        state_q <= ST_SLEEP;
                        wfi_q   <= 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (bus.irq_pending || timer_expire) begin
                        state_q  <= ST_WAKE;
                        wfi_q    <= 1'b0;
                        settle_q <= SETTLE_LOAD;
                        pend_q   <= bus.irq_pending ? CAUSE_IRQ : CAUSE_TIMER;
                    end
                end
                ST_WAKE: begin
                    if (settle_q == '0) begin
                        state_q <= ST_RUN;
                        stall_q <= 1'b0;
                        done_q  <= 1'b1;
                        cause_q <= pend_q;
                    end else begin
                        settle_q <= settle_q - SETTLE_W'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // LED writes are accepted only before the pads are gated, keeping led_bus frozen during sleep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= LED_RESET;
        end else if (bus.led_we && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
            led_q <= bus.led_wdata;
        end
    end

    assign bus.led_bus    = led_q;
    assign bus.wfi        = wfi_q;
    assign bus.cpu_stall  = stall_q;
    assign bus.wfi_done   = done_q;
    assign bus.wake_cause = cause_q;

endmodule

// File: tb/tb_wfi_sleep_ctrl.sv
// Self-checking bench for wfi_sleep_ctrl: vector table, multi-cycle corner sequences and
// randomized traffic against a deadline-based reference model (honours WFI_WAKE_TIMER_EN).
module tb_wfi_sleep_ctrl;

    localparam int TIMER_W = 24;
    localparam int SETTLE  = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wfi_sleep_ctrl_if #(.TIMER_W(TIMER_W)) bus ();

    wfi_sleep_ctrl #(
        .TIMER_W       (TIMER_W),
        .SETTLE_CYCLES (SETTLE),
        .LED_RESET     (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic               req;
        logic               idle;
        logic               irq;
        logic               we;
        logic [7:0]         wdata;
        logic [TIMER_W-1:0] ticks;
        logic               expWfi;
        logic               expStall;
        logic               expDone;
        logic [1:0]         expCause;
        logic [7:0]         expLed;
    } vec_t;

    vec_t vecs[16];

    int testsRun    = 0;
    int testsFailed = 0;
    int highCycles;

    // Reference model: tracks absolute cycle deadlines instead of counters.
    bit         mStall, mWfi, mDone, mWaking;
    logic [1:0] mCause, mPend;
    logic [7:0] mLed;
    int         cyc, deadline, releaseAt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.wfi_req     = v.req;
        bus.bus_idle    = v.idle;
        bus.irq_pending = v.irq;
        bus.led_we      = v.we;
        bus.led_wdata   = v.wdata;
        bus.wake_ticks  = v.ticks;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        bus.wfi_req     = 1'b0;
        bus.bus_idle    = 1'b1;
        bus.irq_pending = 1'b0;
        bus.led_we      = 1'b0;
        bus.led_wdata   = 8'h00;
        bus.wake_ticks  = '0;
    endtask

    task automatic modelReset();
        mStall = 0; mWfi = 0; mDone = 0; mWaking = 0;
        mCause = 2'b00; mPend = 2'b00; mLed = 8'h00;
        cyc = 0; deadline = -1; releaseAt = -1;
    endtask

    task automatic modelStep();
        bit running, draining, sleeping, waking;
        cyc++;
        running  = !mStall;
        draining = mStall && !mWfi && !mWaking;
        sleeping = mWfi;
        waking   = mWaking;
        mDone    = 0;
        if ((running || draining) && bus.led_we) mLed = bus.led_wdata;
        if (running) begin
            if (bus.wfi_req) mStall = 1;
        end else if (draining) begin
            if (bus.irq_pending) begin
                mStall = 0; mDone = 1; mCause = 2'b11;
            end else if (bus.bus_idle) begin
                mWfi = 1;
                deadline = -1;
`ifdef WFI_WAKE_TIMER_EN
                if (bus.wake_ticks != '0) deadline = cyc + int'(bus.wake_ticks);
`endif
            end
        end else if (sleeping) begin
            if (bus.irq_pending || cyc == deadline) begin
                mPend = bus.irq_pending ? 2'b01 : 2'b10;
                mWfi = 0; mWaking = 1; releaseAt = cyc + SETTLE;
            end
        end else if (waking && cyc == releaseAt) begin
            mWaking = 0; mStall = 0; mDone = 1; mCause = mPend;
        end
    endtask

    initial begin
        //            req  idle irq  we   wdata  ticks  wfi  stall done cause  led
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,8'hA5,24'd0, 1'b0,1'b0,1'b0,2'b00,8'hA5};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b1,1'b0,2'b00,8'hA5};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,24'd0, 1'b1,1'b1,1'b0,2'b00,8'hA5};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,8'h3C,24'd0, 1'b1,1'b1,1'b0,2'b00,8'hA5};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,24'd0, 1'b1,1'b1,1'b0,2'b00,8'hA5};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,8'h00,24'd0, 1'b0,1'b1,1'b0,2'b00,8'hA5};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b1,8'h3C,24'd0, 1'b0,1'b1,1'b0,2'b00,8'hA5};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,8'h00,24'd0, 1'b0,1'b0,1'b1,2'b01,8'hA5};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b0,1'b0,2'b01,8'hA5};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,8'h11,24'd0, 1'b0,1'b1,1'b0,2'b01,8'h11};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,8'h5A,24'd0, 1'b0,1'b1,1'b0,2'b01,8'h5A};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b1,1'b0,2'b01,8'h5A};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b1,1'b0,2'b01,8'h5A};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b1,1'b0,2'b01,8'h5A};
        vecs[14] = '{1'b0,1'b0,1'b1,1'b0,8'h00,24'd0, 1'b0,1'b0,1'b1,2'b11,8'h5A};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,8'h00,24'd0, 1'b0,1'b0,1'b0,2'b11,8'h5A};

        rst_n = 1'b0;
        setIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset led_bus", 32'(bus.led_bus), 32'h00);
        checkOutput("reset wfi", 32'(bus.wfi), 32'd0);
        checkOutput("reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("reset wfi_done", 32'(bus.wfi_done), 32'd0);
        checkOutput("reset wake_cause", 32'(bus.wake_cause), 32'd0);
        rst_n = 1'b1;
        step();

        // Irq wake with a dropped LED write, then a drain abort.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d wfi", i), 32'(bus.wfi), 32'(vecs[i].expWfi));
            checkOutput($sformatf("vec%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d wfi_done", i), 32'(bus.wfi_done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d wake_cause", i), 32'(bus.wake_cause), 32'(vecs[i].expCause));
            checkOutput($sformatf("vec%0d led_bus", i), 32'(bus.led_bus), 32'(vecs[i].expLed));
        end

        setIdle();
        bus.wake_ticks = 24'd10;
        bus.wfi_req = 1'b1;
        step();
        checkOutput("timer stall", 32'(bus.cpu_stall), 32'd1);
        bus.wfi_req = 1'b0;
        step();
        checkOutput("timer wfi rise", 32'(bus.wfi), 32'd1);
        highCycles = 1;
        for (int k = 0; k < 40 && bus.wfi; k++) begin
            step();
            if (bus.wfi) highCycles++;
        end
`ifdef WFI_WAKE_TIMER_EN
        checkOutput("timer wfi high cycles", 32'(highCycles), 32'd10);
        step();
        checkOutput("timer done early", 32'(bus.wfi_done), 32'd0);
        step();
        checkOutput("timer wfi_done", 32'(bus.wfi_done), 32'd1);
        checkOutput("timer wake_cause", 32'(bus.wake_cause), 32'd2);
`else
        checkOutput("no-timer wfi held", 32'(bus.wfi), 32'd1);
        bus.irq_pending = 1'b1;
        step();
        checkOutput("no-timer irq wake", 32'(bus.wfi), 32'd0);
        bus.irq_pending = 1'b0;
        step();
        step();
        checkOutput("no-timer wfi_done", 32'(bus.wfi_done), 32'd1);
        checkOutput("no-timer wake_cause", 32'(bus.wake_cause), 32'd1);
`endif

        // Irq lands on the same edge the 3-tick timer would expire.
        setIdle();
        bus.wake_ticks = 24'd3;
        bus.wfi_req = 1'b1;
        step();
        bus.wfi_req = 1'b0;
        step();
        checkOutput("simul wfi rise", 32'(bus.wfi), 32'd1);
        step();
        step();
        checkOutput("simul wfi still high", 32'(bus.wfi), 32'd1);
        bus.irq_pending = 1'b1;
        step();
        checkOutput("simul wfi fall", 32'(bus.wfi), 32'd0);
        bus.irq_pending = 1'b0;
        step();
        step();
        checkOutput("simul wfi_done", 32'(bus.wfi_done), 32'd1);
        checkOutput("simul wake_cause", 32'(bus.wake_cause), 32'd1);

        setIdle();
        bus.led_we = 1'b1;
        bus.led_wdata = 8'h77;
        bus.wfi_req = 1'b1;
        step();
        setIdle();
        step();
        checkOutput("midsleep wfi high", 32'(bus.wfi), 32'd1);
        checkOutput("midsleep led", 32'(bus.led_bus), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset wfi", 32'(bus.wfi), 32'd0);
        checkOutput("async reset led_bus", 32'(bus.led_bus), 32'h00);
        checkOutput("async reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("async reset wake_cause", 32'(bus.wake_cause), 32'd0);
        step();
        rst_n = 1'b1;
        modelReset();

        for (int c = 0; c < 3000; c++) begin
            bus.wfi_req     = ($urandom_range(0, 3) == 0);
            bus.bus_idle    = 1'($urandom_range(0, 1));
            bus.irq_pending = ($urandom_range(0, 9) == 0);
            bus.led_we      = 1'($urandom_range(0, 1));
            bus.led_wdata   = 8'($urandom);
            bus.wake_ticks  = TIMER_W'($urandom_range(0, 12));
            modelStep();
            step();
            checkOutput($sformatf("random cyc%0d {wfi,stall,done,cause,led}", c),
                        {19'b0, bus.wfi, bus.cpu_stall, bus.wfi_done, bus.wake_cause, bus.led_bus},
                        {19'b0, mWfi, mStall, mDone, mCause, mLed});
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wfi_sleep_ctrl.md
# wfi_sleep_ctrl

Sleep controller and LED output register feeding the Bank-2 pad stage. It turns the core's WFI request into a clean sleep sequence: drain the bus, assert `wfi`, wait for an interrupt or a wake timer, then settle the pads before releasing the core. It also owns the 8-bit LED register whose value drives the pads. `led_bus` is held stable for the whole time `wfi` is high.

## Interface
- `TIMER_W`, 24: width of the wake-timer counter and `wake_ticks`.
- `SETTLE_CYCLES`, 2: cycles spent in WAKE after `wfi` drops, before the core is released; minimum 1.
- `LED_RESET`, 8'h00: reset value of `led_bus`.
- `clk` in 1: 12 MHz HFOSC clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wfi_req` in 1: core decoded a WFI; single-cycle pulse.
- `bus_idle` in 1: no outstanding bus transaction.
- `irq_pending` in 1: level; any enabled interrupt pending.
- `wake_ticks` in TIMER_W: sleep timeout in cycles; 0 means no timeout.
- `led_we` in 1: LED register write strobe.
- `led_wdata` in 8: LED write data.
- `led_bus` out 8: LED register value to the pad stage.
- `wfi` out 1: 1 means idle; gates the pad output enables.
- `cpu_stall` out 1: holds the core pipeline.
- `wfi_done` out 1: one-cycle pulse when the core is released.
- `wake_cause` out 2: 00 none, 01 irq, 10 timer, 11 abort. Held until the next `wfi_done`.

## Operation
- FSM states: RUN, DRAIN, SLEEP, WAKE. All outputs are registered.
- Reset values: state RUN, `wfi`=0, `cpu_stall`=0, `wfi_done`=0, `wake_cause`=00, `led_bus`=LED_RESET, timer 0, settle count 0.
- **RUN**
  - `wfi_req`=1 moves the FSM to DRAIN and sets `cpu_stall`=1.
- **DRAIN**
  - If `irq_pending`=1: go to RUN, pulse `wfi_done`, set `wake_cause`=11, clear `cpu_stall`. This takes priority over `bus_idle`.
  - Otherwise, if `bus_idle`=1: go to SLEEP, set `wfi`=1, load the timer with `wake_ticks`.
- **SLEEP**
  - `irq_pending`=1: go to WAKE with cause 01.
  - Otherwise, timer nonzero and equal to 1: go to WAKE with cause 10. Otherwise a nonzero timer decrements.
  - A timer loaded with 0 never expires.
  - On entering WAKE: `wfi`=0 and the settle count loads SETTLE_CYCLES−1.
- **WAKE**
  - The settle count decrements each cycle.
  - At 0: go to RUN, clear `cpu_stall`, pulse `wfi_done`.
  - `irq_pending` has no effect in WAKE.
- `wfi_req` is ignored in DRAIN, SLEEP and WAKE.
- **LED register**
  - `led_we` loads `led_wdata` in RUN and DRAIN, including the cycle `wfi_req` is seen.
  - Writes in SLEEP or WAKE are dropped, so `led_bus` is constant while `wfi`=1.
- Simultaneous irq and timer expiry: cause is 01.
- Reset asserted mid-sleep: all outputs go to their reset values immediately (asynchronous). `wfi` falls without a WAKE phase.

## Timing
- `wfi_req` at edge N gives `cpu_stall`=1 after edge N.
- If `bus_idle` is already high in DRAIN, `wfi`=1 after edge N+1. Minimum request-to-sleep latency is 2 cycles.
- Wake event sampled at edge M: `wfi`=0 after M. `cpu_stall`=0 and `wfi_done`=1 after M+SETTLE_CYCLES.
- The settle window covers the pad stage's one-cycle registered output enable.
- Timer: `wake_ticks`=T>0 loaded on SLEEP entry gives expiry T cycles after `wfi` rises, absent irq.
- `wfi_done` is exactly one cycle wide. `wake_cause` updates in the same cycle.

## Configuration
- `WFI_WAKE_TIMER_EN`
  - Defined: wake timer and `wake_ticks` are active as above.
  - Undefined: the timer logic is removed, `wake_ticks` is ignored, SLEEP exits only on `irq_pending`, and cause 10 never occurs.

## Structure
- Shared package holds:
  - state encoding: RUN=0, DRAIN=1, SLEEP=2, WAKE=3;
  - `wake_cause` constants: CAUSE_NONE, CAUSE_IRQ, CAUSE_TIMER, CAUSE_ABORT.
- One sub-module, `wfi_wake_timer`: loadable down-counter with load, enable and expire outputs. It is instantiated only under `WFI_WAKE_TIMER_EN`.
- The LED register lives in the top level.

## Test plan
- **Reset:** release `rst_n` → `led_bus`=00, `wfi`=0, `cpu_stall`=0, `wake_cause`=00.
- **Irq wake:** write A5 → `led_bus`=A5. `wfi_req` with `bus_idle`=1 → `wfi`=1 two cycles later. `led_we` 3C during SLEEP → `led_bus` stays A5. `irq_pending` → `wfi`=0 next cycle, `wfi_done` 2 cycles later, `wake_cause`=01.
- **Timer wake:** `wake_ticks`=10, no irq → `wfi` high exactly 10 cycles, `wake_cause`=10. The same test with the macro undefined → `wfi` stays high until irq.
- **Drain abort:** `wfi_req` with `bus_idle`=0 for 5 cycles, then `irq_pending` → `wfi` never rises, `wfi_done` pulse, `wake_cause`=11.
- **Simultaneous events:** irq coincides with the timer-expiry cycle → `wake_cause`=01. `wfi_req` during WAKE is ignored.
- **Reset mid-sleep:** assert `rst_n` low while `wfi`=1 → `wfi`=0 and `led_bus`=00 without waiting for a clock edge.
